// File: rtl/mcdf_arb_pkg.sv
// Shared types and defaults for the MCDF N-channel arbiter.
// Holds the FSM state enum, channel-index width helper and default parameters.
package mcdf_arb_pkg;

  localparam int CH_NUM_DEF = 4;
  localparam int PRIO_W_DEF = 2;
  localparam int LEN_W_DEF  = 6;
  localparam int DATA_W_DEF = 32;
  localparam int RR_EN_DEF  = 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  // Channel-index width; never below 1 so a 2-channel build still has an id bit.
  function automatic int clog2_ch(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mcdf_arb_pick.sv
// Combinational winner selection: lowest priority value, ties by round-robin or lowest index.
// Zero latency; no flow control of its own.
module mcdf_arb_pick
  import mcdf_arb_pkg::*;
#(
  parameter int  CH_NUM = CH_NUM_DEF,
  parameter int  PRIO_W = PRIO_W_DEF,
  parameter int  RR_EN  = RR_EN_DEF,
  localparam int ID_W   = clog2_ch(CH_NUM)
) (
  input  logic [CH_NUM-1:0]        elig,
  input  logic [CH_NUM*PRIO_W-1:0] prio,
  input  logic [ID_W-1:0]          last_win,
  output logic [ID_W-1:0]          winner,
  output logic                     any_elig
);

  logic [PRIO_W-1:0] prio_a [CH_NUM];

  for (genvar c = 0; c < CH_NUM; c++) begin : g_unpack
    assign prio_a[c] = prio[c*PRIO_W +: PRIO_W];
  end

  // Scan in tie-break order; a strict '<' keeps the first candidate seen at equal priority.
  always_comb begin
    logic [PRIO_W-1:0] best_prio;
    logic [ID_W-1:0]   idx;
    int                idx_int;
    winner    = '0;
    any_elig  = 1'b0;
    best_prio = '1;
    idx       = '0;
    idx_int   = 0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx_int = (RR_EN != 0) ? ((int'(last_win) + 1 + k) % CH_NUM) : k;
      idx     = ID_W'(idx_int);
      if (elig[idx] && (!any_elig || (prio_a[idx] < best_prio))) begin
        any_elig  = 1'b1;
        best_prio = prio_a[idx];
        winner    = idx;
      end
    end
  end

endmodule

// File: rtl/mcdf_arb_n.sv
// N-channel MCDF arbiter: grants one packet at a time and owns the data path until its last word.
// Grant visible 1 cycle after the request edge; words advance only on f2a_rd_i.
module mcdf_arb_n
  import mcdf_arb_pkg::*;
#(
  parameter int  CH_NUM = CH_NUM_DEF,
  parameter int  PRIO_W = PRIO_W_DEF,
  parameter int  LEN_W  = LEN_W_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  RR_EN  = RR_EN_DEF,
  localparam int ID_W   = clog2_ch(CH_NUM)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CH_NUM-1:0]        slv_en_i,
  input  logic [CH_NUM*PRIO_W-1:0] slv_prio_i,
  input  logic [CH_NUM-1:0]        slv_req_i,
  input  logic [CH_NUM*LEN_W-1:0]  slv_len_i,
  input  logic [CH_NUM*DATA_W-1:0] slv_data_i,
  output logic [CH_NUM-1:0]        a2s_ack_o,
  output logic [CH_NUM-1:0]        a2s_rd_o,
  input  logic                     f2a_id_req_i,
  input  logic                     f2a_rd_i,
  output logic                     a2f_val_o,
  output logic [ID_W-1:0]          a2f_id_o,
  output logic [LEN_W-1:0]         a2f_len_o,
  output logic [DATA_W-1:0]        a2f_data_o,
  output logic                     a2f_last_o
);

  arb_state_t        state, state_nxt;
  logic [ID_W-1:0]   sel, last_win, winner;
  logic [LEN_W-1:0]  len, cnt;
  logic [CH_NUM-1:0] elig, ack;
  logic              any_elig, val, last_word, grant;

  logic [LEN_W-1:0]  len_a  [CH_NUM];
  logic [DATA_W-1:0] data_a [CH_NUM];

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    assign len_a[c]  = slv_len_i[c*LEN_W +: LEN_W];
    assign data_a[c] = slv_data_i[c*DATA_W +: DATA_W];
    assign elig[c]   = slv_en_i[c] && slv_req_i[c] && (len_a[c] != '0);
  end

  mcdf_arb_pick #(
    .CH_NUM (CH_NUM),
    .PRIO_W (PRIO_W),
    .RR_EN  (RR_EN)
  ) u_pick (
    .elig     (elig),
    .prio     (slv_prio_i),
    .last_win (last_win),
    .winner   (winner),
    .any_elig (any_elig)
  );

  assign last_word = (cnt == len - LEN_W'(1));
  assign grant     = (state == ARB_IDLE) && f2a_id_req_i && any_elig;

  always_comb begin
    state_nxt  = state;
    a2s_rd_o   = '0;
    a2f_data_o = '0;
    a2f_last_o = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (f2a_id_req_i && any_elig) state_nxt = ARB_XFER;
      end
      ARB_XFER: begin
        a2f_data_o = data_a[sel];
        a2f_last_o = last_word;
        if (f2a_rd_i) begin
          a2s_rd_o = CH_NUM'(1) << sel;
          if (last_word) state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // len and sel are frozen at grant so mid-packet control changes cannot disturb the transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ARB_IDLE;
      sel      <= '0;
      len      <= '0;
      cnt      <= '0;
      last_win <= ID_W'(CH_NUM - 1);
      ack      <= '0;
      val      <= 1'b0;
    end else begin
      state <= state_nxt;
      ack   <= '0;
      val   <= 1'b0;
      if (grant) begin
        sel      <= winner;
        len      <= len_a[winner];
        cnt      <= '0;
        last_win <= winner;
        ack      <= CH_NUM'(1) << winner;
        val      <= 1'b1;
      end else if ((state == ARB_XFER) && f2a_rd_i) begin
        cnt <= cnt + LEN_W'(1);
      end
    end
  end

  assign a2s_ack_o = ack;
  assign a2f_val_o = val;
  assign a2f_id_o  = sel;
  assign a2f_len_o = len;

endmodule

// File: tb/tb_mcdf_arb_n.sv
// Scoreboard bench for mcdf_arb_n: packet-level reference model plus emulated channel FIFOs.
// A fixed-priority instance runs alongside for the tie-break comparison.
module tb_mcdf_arb_n;
  import mcdf_arb_pkg::*;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int LW = 6;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  slv_en_i, slv_req_i;
  logic [N*PW-1:0] slv_prio_i;
  logic [N*LW-1:0] slv_len_i;
  logic [N*DW-1:0] slv_data_i;
  logic [N-1:0]  a2s_ack_o, a2s_rd_o;
  logic          f2a_id_req_i, f2a_rd_i;
  logic          a2f_val_o, a2f_last_o;
  logic [IW-1:0] a2f_id_o;
  logic [LW-1:0] a2f_len_o;
  logic [DW-1:0] a2f_data_o;

  logic          id_req0;
  logic [N-1:0]  ack0, rd0;
  logic          val0, last0;
  logic [IW-1:0] id0;
  logic [LW-1:0] len0;
  logic [DW-1:0] data0;

  always #5 clk_i = ~clk_i;

  mcdf_arb_n #(.CH_NUM(N), .PRIO_W(PW), .LEN_W(LW), .DATA_W(DW), .RR_EN(1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .slv_en_i(slv_en_i), .slv_prio_i(slv_prio_i),
    .slv_req_i(slv_req_i), .slv_len_i(slv_len_i), .slv_data_i(slv_data_i),
    .a2s_ack_o(a2s_ack_o), .a2s_rd_o(a2s_rd_o), .f2a_id_req_i(f2a_id_req_i),
    .f2a_rd_i(f2a_rd_i), .a2f_val_o(a2f_val_o), .a2f_id_o(a2f_id_o),
    .a2f_len_o(a2f_len_o), .a2f_data_o(a2f_data_o), .a2f_last_o(a2f_last_o));

  mcdf_arb_n #(.CH_NUM(N), .PRIO_W(PW), .LEN_W(LW), .DATA_W(DW), .RR_EN(0)) u_fix (
    .clk_i(clk_i), .rst_i(rst_i), .slv_en_i(slv_en_i), .slv_prio_i(slv_prio_i),
    .slv_req_i(slv_req_i), .slv_len_i(slv_len_i), .slv_data_i(slv_data_i),
    .a2s_ack_o(ack0), .a2s_rd_o(rd0), .f2a_id_req_i(id_req0),
    .f2a_rd_i(f2a_rd_i), .a2f_val_o(val0), .a2f_id_o(id0),
    .a2f_len_o(len0), .a2f_data_o(data0), .a2f_last_o(last0));

  typedef struct {int id; int len;} pkt_t;
  typedef struct {int ch; logic [DW-1:0] dat; bit last;} word_t;

  pkt_t  q_pkt[$];
  word_t q_word[$];
  int    q_fix[$];
  int    checks = 0;
  int    errors = 0;
  bit    in_pkt = 0;
  int    popped[N];
  int    base[N];
  int    m_last = N - 1;

  function automatic logic [DW-1:0] word_of(int c, int n);
    return {4'(c), 4'hA, 24'(n)};
  endfunction

  // Channel FIFO heads: word n of channel c is presented after n reads from that channel.
  always_comb begin
    slv_data_i = '0;
    for (int c = 0; c < N; c++) slv_data_i[c*DW +: DW] = word_of(c, popped[c]);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic bail(string why);
    checks++;
    errors++;
    $display("FAIL %s at %0t", why, $time);
    finish_sim();
  endtask

  task automatic set_ch(int c, bit en, bit req, int prio, int len);
    slv_en_i[c]            = en;
    slv_req_i[c]           = req;
    slv_prio_i[c*PW +: PW] = PW'(prio);
    slv_len_i[c*LW +: LW]  = LW'(len);
  endtask

  function automatic bit elig(int c);
    return slv_en_i[c] && slv_req_i[c] && (slv_len_i[c*LW +: LW] != 0);
  endfunction

  function automatic int prio_of(int c);
    return int'(slv_prio_i[c*PW +: PW]);
  endfunction

  // Reference: smallest priority value among eligible channels, then first such channel in tie order.
  function automatic int model_pick(bit rr, int last);
    int best_p;
    best_p = 1 << PW;
    for (int c = 0; c < N; c++)
      if (elig(c) && prio_of(c) < best_p) best_p = prio_of(c);
    if (best_p == (1 << PW)) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = rr ? (last + 1 + k) % N : k;
      if (elig(c) && prio_of(c) == best_p) return c;
    end
    return -1;
  endfunction

  task automatic check_zero(string name);
    chk(name, {a2s_ack_o, a2s_rd_o, a2f_val_o, a2f_id_o, a2f_len_o, a2f_data_o, a2f_last_o}, 0);
  endtask

  task automatic resync_model();
    m_last = N - 1;
    for (int c = 0; c < N; c++) base[c] = popped[c];
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    resync_model();
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  // rd_mode: 0 always read, 1 toggle starting with a read, 2 random. rst_at > 0 aborts at that word index.
  task automatic run_txn(int rd_mode, bit mutate, bit fix_too, int rst_at);
    int w, len, cyc;
    word_t wd;
    pkt_t  p;
    w = model_pick(1'b1, m_last);
    if (w < 0) begin
      f2a_id_req_i = 1'b1;
      repeat (3) begin
        @(posedge clk_i);
        #1;
        chk("no_grant", a2f_val_o, 0);
      end
      f2a_id_req_i = 1'b0;
      return;
    end
    len = int'(slv_len_i[w*LW +: LW]);
    p.id = w;
    p.len = len;
    q_pkt.push_back(p);
    for (int k = 0; k < len; k++) begin
      wd.ch = w;
      wd.dat = word_of(w, base[w] + k);
      wd.last = (k == len - 1);
      q_word.push_back(wd);
    end
    base[w] += len;
    m_last = w;
    if (fix_too) begin
      q_fix.push_back(model_pick(1'b0, 0));
      id_req0 = 1'b1;
    end
    f2a_id_req_i = 1'b1;
    @(posedge clk_i);
    #1;
    f2a_id_req_i = 1'b0;
    id_req0 = 1'b0;
    chk("grant_latency", a2f_val_o, 1);
    if (!a2f_val_o) bail("grant_timeout");
    if (mutate)
      for (int c = 0; c < N; c++)
        set_ch(c, (c == w) ? 1'b0 : 1'($urandom % 2), 1'($urandom % 2), $urandom % 4, $urandom % 64);
    cyc = 0;
    do begin
      if (rst_at > 0 && cyc == rst_at) begin
        rst_i = 1'b1;
        #1;
        check_zero("reset_abort");
        repeat (2) @(posedge clk_i);
        #1;
        resync_model();
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        return;
      end
      case (rd_mode)
        0:       f2a_rd_i = 1'b1;
        1:       f2a_rd_i = (cyc % 2 == 0);
        default: f2a_rd_i = ($urandom % 3 != 0);
      endcase
      @(posedge clk_i);
      #1;
      cyc++;
      if (cyc > 300) bail("packet_timeout");
    end while (in_pkt);
    f2a_rd_i = 1'($urandom % 2);
  endtask

  // Monitor: pops expectations whenever the DUT shows a grant or a data word.
  always @(negedge clk_i) begin
    pkt_t  p;
    word_t w;
    if (rst_i) begin
      in_pkt = 0;
      q_pkt.delete();
      q_word.delete();
      q_fix.delete();
    end else begin
      if (a2f_val_o) begin
        if (q_pkt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got id %0d expected no grant", a2f_id_o);
        end else begin
          p = q_pkt.pop_front();
          chk("grant_id", a2f_id_o, p.id);
          chk("grant_len", a2f_len_o, p.len);
          chk("grant_ack", a2s_ack_o, 64'(1) << p.id);
          in_pkt = 1;
        end
      end else begin
        chk("ack_idle", a2s_ack_o, 0);
      end
      if (in_pkt) begin
        if (q_word.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_underflow: got transfer expected none");
          in_pkt = 0;
        end else begin
          w = q_word[0];
          chk("rd_data", a2f_data_o, w.dat);
          chk("rd_last", a2f_last_o, w.last);
          if (f2a_rd_i) begin
            chk("rd_strobe", a2s_rd_o, 64'(1) << w.ch);
            void'(q_word.pop_front());
            if (w.last) in_pkt = 0;
          end else begin
            chk("rd_hold", a2s_rd_o, 0);
          end
        end
      end else begin
        chk("idle_out", {a2s_rd_o, a2f_data_o, a2f_last_o}, 0);
      end
      for (int c = 0; c < N; c++) if (a2s_rd_o[c]) popped[c]++;
      if (val0) begin
        if (q_fix.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fix_grant: got id %0d expected no grant", id0);
        end else begin
          chk("fix_id", id0, q_fix.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    bail("watchdog");
  end

  initial begin
    rst_i = 1'b1;
    slv_en_i = '0;
    slv_req_i = '0;
    slv_prio_i = '0;
    slv_len_i = '0;
    f2a_id_req_i = 1'b0;
    f2a_rd_i = 1'b0;
    id_req0 = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("reset_outputs");
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    set_ch(1, 1, 1, 1, 4);
    run_txn(0, 0, 0, 0);

    set_ch(1, 0, 0, 0, 0);
    set_ch(0, 1, 1, 2, 3);
    set_ch(2, 1, 1, 0, 3);
    run_txn(0, 0, 0, 0);
    set_ch(2, 1, 0, 0, 3);
    run_txn(0, 0, 0, 0);

    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, 1, 1, 1, 2);
    repeat (5) run_txn(0, 0, 1, 0);

    for (int c = 0; c < N; c++) set_ch(c, 0, 0, 0, 0);
    set_ch(3, 0, 1, 0, 5);
    set_ch(1, 1, 1, 3, 2);
    run_txn(0, 0, 0, 0);
    set_ch(3, 1, 1, 0, 0);
    run_txn(0, 0, 0, 0);

    for (int c = 0; c < N; c++) set_ch(c, 0, 0, 0, 0);
    set_ch(3, 1, 1, 0, 8);
    run_txn(2, 1, 0, 0);

    for (int c = 0; c < N; c++) set_ch(c, 0, 0, 0, 0);
    set_ch(2, 1, 1, 2, 3);
    run_txn(1, 0, 0, 0);

    for (int c = 0; c < N; c++) set_ch(c, 0, 0, 0, 0);
    set_ch(0, 1, 1, 1, 8);
    run_txn(0, 0, 0, 2);
    set_ch(0, 1, 1, 1, 2);
    set_ch(1, 1, 1, 1, 2);
    run_txn(0, 0, 0, 0);

    repeat (150) begin
      for (int c = 0; c < N; c++)
        set_ch(c, ($urandom % 5) != 0, ($urandom % 4) != 0, $urandom % 4, $urandom % 8);
      run_txn(2, ($urandom % 3) == 0, 0, 0);
    end

    repeat (2) @(posedge clk_i);
    #1;
    chk("queues_drained", q_pkt.size() + q_word.size() + q_fix.size(), 0);
    finish_sim();
  end

endmodule
